acc_block_sequencer: RTL and testbench

- Sequences the memory/accumulator datapath for one block-sum job.
- On a start request, it performs these steps in order:
  - clears the accumulator;
  - reads `count` consecutive words from `src_base`, loading each into the accumulator;
  - transfers the sum to `acc_data_out`;
  - writes the sum to memory at `dst_addr`;
  - pulses `done`.
- Replaces the fixed-pattern FSM controller when software-selected address ranges are needed.
- The accumulator and the 32-word memory are unchanged.

---
 rtl/acc_block_sequencer_if.sv | 48 ++++
 rtl/acc_block_sequencer.sv | 178 +++++++++++++++++
 tb/tb_acc_block_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_block_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_block_sequencer_if
//  Brief    : Job request / status and memory-accumulator strobe bundle for
//             acc_block_sequencer. The 'error' signal exists only when
//             ACC_SEQ_RANGE_CHECK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface acc_block_sequencer_if;
  logic       start;
  logic [4:0] src_base;
  logic [5:0] count;
  logic [4:0] dst_addr;
  logic       busy;
  logic       done;
  logic [4:0] mem_address;
  logic       mem_read_enable;
  logic       mem_write_enable;
  logic       acc_clear;
  logic       acc_load;
  logic       acc_transfer;
`ifdef ACC_SEQ_RANGE_CHECK_EN
  logic       error;

  modport slave (
    input  start, src_base, count, dst_addr,
    output busy, done, mem_address, mem_read_enable, mem_write_enable,
           acc_clear, acc_load, acc_transfer, error
  );
  modport master (
    output start, src_base, count, dst_addr,
    input  busy, done, mem_address, mem_read_enable, mem_write_enable,
           acc_clear, acc_load, acc_transfer, error
  );
`else
  modport slave (
    input  start, src_base, count, dst_addr,
    output busy, done, mem_address, mem_read_enable, mem_write_enable,
           acc_clear, acc_load, acc_transfer
  );
  modport master (
    output start, src_base, count, dst_addr,
    input  busy, done, mem_address, mem_read_enable, mem_write_enable,
           acc_clear, acc_load, acc_transfer
  );
`endif
endinterface
`default_nettype wire

// File: rtl/acc_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : acc_block_sequencer
//  Brief    : Runs one block-sum job: clear accumulator, read 'count' words
//             from src_base (addresses wrap mod 32), transfer the sum, write
//             it to dst_addr, pulse done. acc_load is the read strobe delayed
//             by MEM_LAT cycles.
//             Optional macro ACC_SEQ_RANGE_CHECK_EN: refuse jobs whose source
//             range would wrap past word 31 and pulse 'error' instead.
//  Revision : 1.0 - initial release
// ============================================================================
module acc_block_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  acc_block_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CLEAR    = 3'd1,
    S_READ     = 3'd2,
    S_DRAIN    = 3'd3,
    S_TRANSFER = 3'd4,
    S_WRITE    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  localparam logic [5:0] c_max_words  = 6'd32;
  localparam bit         c_has_drain  = (MEM_LAT > 0);
  localparam logic [5:0] c_drain_last = (MEM_LAT > 0) ? 6'(MEM_LAT - 1) : 6'd0;

  state_t     r_state;
  state_t     w_next_state;
  logic [4:0] r_src;
  logic [4:0] r_dst;
  logic [5:0] r_len;
  logic [5:0] r_idx;
  logic [4:0] r_addr_hold;
  logic [5:0] w_len_in;
  logic       w_range_bad;
  logic       w_accept;
  logic [4:0] w_addr;
  logic       w_rd;
  logic       w_wr;
  logic       w_clr;
  logic       w_xfer;
  logic       w_done;
  logic       w_load;

  // Requests for more than 32 words collapse to a full sweep of the memory.
  assign w_len_in = (bus.count > c_max_words) ? c_max_words : bus.count;

`ifdef ACC_SEQ_RANGE_CHECK_EN
  // A non-empty job whose source range would run past word 31 is refused.
  assign w_range_bad = (w_len_in != 6'd0) &&
                       ((7'(bus.src_base) + 7'(w_len_in)) > 7'd32);
`else
  assign w_range_bad = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.start && !w_range_bad;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Capture the job on the accepting edge; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
    end else if (w_accept) begin
      r_src <= bus.src_base;
      r_dst <= bus.dst_addr;
      r_len <= w_len_in;
    end
  end

  // Step counter for READ / DRAIN; restarts on every state change.
  always_ff @(posedge clock) begin
    if (reset || (w_next_state != r_state)) r_idx <= '0;
    else if ((r_state == S_READ) || (r_state == S_DRAIN)) r_idx <= r_idx + 6'd1;
  end

  // mem_address keeps its last driven value outside the strobe states.
  always_ff @(posedge clock) begin
    if (reset) r_addr_hold <= '0;
    else       r_addr_hold <= w_addr;
  end

  // Next-state decode and Moore strobes.
  always_comb begin
    w_next_state = r_state;
    w_addr       = r_addr_hold;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_clr        = 1'b0;
    w_xfer       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = (w_len_in == 6'd0) ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        w_clr        = 1'b1;
        w_next_state = S_READ;
      end
      S_READ: begin
        w_rd   = 1'b1;
        w_addr = r_src + r_idx[4:0];
        if (r_idx == (r_len - 6'd1))
          w_next_state = c_has_drain ? S_DRAIN : S_TRANSFER;
      end
      S_DRAIN: begin
        if (r_idx == c_drain_last) w_next_state = S_TRANSFER;
      end
      S_TRANSFER: begin
        w_xfer       = 1'b1;
        w_next_state = S_WRITE;
      end
      S_WRITE: begin
        w_wr         = 1'b1;
        w_addr       = r_dst;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_done       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // acc_load follows the read strobe by the memory latency.
  generate
    if (MEM_LAT == 0) begin : g_load_direct
      assign w_load = w_rd;
    end else begin : g_load_pipe
      logic [MEM_LAT-1:0] r_load_pipe;
      // Shift the read strobe down the latency line; reset flushes it.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_load_pipe <= '0;
        end else begin
          r_load_pipe[0] <= w_rd;
          for (int k = 1; k < MEM_LAT; k++) r_load_pipe[k] <= r_load_pipe[k-1];
        end
      end
      assign w_load = r_load_pipe[MEM_LAT-1];
    end
  endgenerate

`ifdef ACC_SEQ_RANGE_CHECK_EN
  logic r_err;
  // One-cycle error pulse in the cycle after a refused start.
  always_ff @(posedge clock) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= (r_state == S_IDLE) && bus.start && w_range_bad;
  end
  assign bus.error = r_err;
`endif

  assign bus.busy             = (r_state != S_IDLE);
  assign bus.done             = w_done;
  assign bus.mem_address      = w_addr;
  assign bus.mem_read_enable  = w_rd;
  assign bus.mem_write_enable = w_wr;
  assign bus.acc_clear        = w_clr;
  assign bus.acc_load         = w_load;
  assign bus.acc_transfer     = w_xfer;

endmodule
`default_nettype wire

// File: tb/tb_acc_block_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_acc_block_sequencer
//  Brief    : Bench for acc_block_sequencer. Three instances (MEM_LAT = 0, 1,
//             3) share one set of job inputs. A behavioural memory and
//             accumulator react to each instance's strobes; expectations come
//             from address arithmetic, the latency formula and a golden
//             memory image.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_acc_block_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [4:0] src_base = '0;
  logic [5:0] count = '0;
  logic [4:0] dst_addr = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_of [3] = '{0, 1, 3};

  acc_block_sequencer_if bus_l0 ();
  acc_block_sequencer_if bus_l1 ();
  acc_block_sequencer_if bus_l3 ();

  assign bus_l0.start = start;  assign bus_l0.src_base = src_base;
  assign bus_l0.count = count;  assign bus_l0.dst_addr = dst_addr;
  assign bus_l1.start = start;  assign bus_l1.src_base = src_base;
  assign bus_l1.count = count;  assign bus_l1.dst_addr = dst_addr;
  assign bus_l3.start = start;  assign bus_l3.src_base = src_base;
  assign bus_l3.count = count;  assign bus_l3.dst_addr = dst_addr;

  acc_block_sequencer #(.MEM_LAT(0)) dut_l0 (.clock(clock), .reset(reset), .bus(bus_l0.slave));
  acc_block_sequencer #(.MEM_LAT(1)) dut_l1 (.clock(clock), .reset(reset), .bus(bus_l1.slave));
  acc_block_sequencer #(.MEM_LAT(3)) dut_l3 (.clock(clock), .reset(reset), .bus(bus_l3.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Per-instance views of the outputs (index 0/1/2 = MEM_LAT 0/1/3).
  logic [2:0] m_rd, m_wr, m_clr, m_ld, m_xf, m_dn, m_busy, m_err;
  logic [4:0] m_addr [3];
  assign m_rd   = {bus_l3.mem_read_enable,  bus_l1.mem_read_enable,  bus_l0.mem_read_enable};
  assign m_wr   = {bus_l3.mem_write_enable, bus_l1.mem_write_enable, bus_l0.mem_write_enable};
  assign m_clr  = {bus_l3.acc_clear,        bus_l1.acc_clear,        bus_l0.acc_clear};
  assign m_ld   = {bus_l3.acc_load,         bus_l1.acc_load,         bus_l0.acc_load};
  assign m_xf   = {bus_l3.acc_transfer,     bus_l1.acc_transfer,     bus_l0.acc_transfer};
  assign m_dn   = {bus_l3.done,             bus_l1.done,             bus_l0.done};
  assign m_busy = {bus_l3.busy,             bus_l1.busy,             bus_l0.busy};
`ifdef ACC_SEQ_RANGE_CHECK_EN
  assign m_err  = {bus_l3.error,            bus_l1.error,            bus_l0.error};
`else
  assign m_err  = 3'b000;
`endif
  assign m_addr[0] = bus_l0.mem_address;
  assign m_addr[1] = bus_l1.mem_address;
  assign m_addr[2] = bus_l3.mem_address;

  // Golden memory image (main process) and strobe-driven datapath models.
  logic [15:0] exp_mem [32];
  logic [15:0] dmem [3][32];
  logic [15:0] acc [3];
  logic [15:0] acc_out [3];
  int rd_tot[3], ld_tot[3], ld_ptr[3], clr_tot[3], xf_tot[3], wr_tot[3];
  int dn_tot[3], busy_tot[3], excl_tot[3], err_tot[3];
  int xf_cyc[3], wr_cyc[3], dn_cyc[3], err_cyc[3];
  logic [4:0]  wr_addr[3], dn_addr[3];
  logic [15:0] wr_data[3];
  int          rd_cyc [3][256];
  int          ld_cyc [3][256];
  logic [4:0]  rd_addr[3][256];
  logic [15:0] rd_data[3][256];

  initial begin : monitor
    int nstb;
    @(negedge clock);
    for (int k = 0; k < 3; k++)
      for (int a = 0; a < 32; a++) dmem[k][a] = exp_mem[a];
    forever begin
      for (int k = 0; k < 3; k++) begin
        if (m_rd[k] === 1'b1) begin
          rd_addr[k][rd_tot[k] % 256] = m_addr[k];
          rd_cyc[k][rd_tot[k] % 256]  = cyc;
          rd_data[k][rd_tot[k] % 256] = dmem[k][m_addr[k]];
          rd_tot[k]++;
        end
        if (m_ld[k] === 1'b1) begin
          ld_cyc[k][ld_tot[k] % 256] = cyc;
          acc[k] = acc[k] + rd_data[k][ld_ptr[k] % 256];
          ld_ptr[k]++;
          ld_tot[k]++;
        end
        if (m_clr[k] === 1'b1) begin acc[k] = '0; ld_ptr[k] = rd_tot[k]; clr_tot[k]++; end
        if (m_xf[k] === 1'b1) begin acc_out[k] = acc[k]; xf_tot[k]++; xf_cyc[k] = cyc; end
        if (m_wr[k] === 1'b1) begin
          dmem[k][m_addr[k]] = acc_out[k];
          wr_tot[k]++; wr_cyc[k] = cyc; wr_addr[k] = m_addr[k]; wr_data[k] = acc_out[k];
        end
        if (m_dn[k] === 1'b1) begin dn_tot[k]++; dn_cyc[k] = cyc; dn_addr[k] = m_addr[k]; end
        if (m_busy[k] === 1'b1) busy_tot[k]++;
        if (m_err[k] === 1'b1) begin err_tot[k]++; err_cyc[k] = cyc; end
        nstb = int'(m_rd[k] === 1'b1) + int'(m_wr[k] === 1'b1) + int'(m_clr[k] === 1'b1)
             + int'(m_xf[k] === 1'b1) + int'(m_dn[k] === 1'b1);
        if (nstb > 1 || (m_ld[k] === 1'b1 && (m_wr[k] | m_clr[k] | m_xf[k] | m_dn[k]) === 1'b1))
          excl_tot[k]++;
      end
      @(negedge clock);
    end
  end

  // Runs one job on all instances and checks it against the reference rules.
  task automatic run_job(input int src, input int cnt, input int dst, input bit pulse);
    int n, t0, w, exp_done, bad;
    logic [15:0] sum;
    bit all_done;
    int s_rd[3], s_ld[3], s_clr[3], s_xf[3], s_wr[3], s_dn[3], s_busy[3], s_ex[3];
    n = (cnt > 32) ? 32 : cnt;
    sum = '0;
    for (int i = 0; i < n; i++) sum = sum + exp_mem[(src + i) % 32];
    for (int k = 0; k < 3; k++) begin
      s_rd[k] = rd_tot[k]; s_ld[k] = ld_tot[k]; s_clr[k] = clr_tot[k]; s_xf[k] = xf_tot[k];
      s_wr[k] = wr_tot[k]; s_dn[k] = dn_tot[k]; s_busy[k] = busy_tot[k]; s_ex[k] = excl_tot[k];
    end
    @(negedge clock);
    src_base = 5'(src); count = 6'(cnt); dst_addr = 5'(dst); start = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start = 1'b0;
    src_base = 5'($urandom); count = 6'($urandom); dst_addr = 5'($urandom);
    if (pulse && n > 0) begin
      @(negedge clock); @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
    end
    w = 0; all_done = 1'b0;
    while (!all_done && w < 150) begin
      @(negedge clock); #1; w++;
      all_done = 1'b1;
      for (int k = 0; k < 3; k++) if (dn_tot[k] - s_dn[k] < 1) all_done = 1'b0;
    end
    checks++;
    if (!all_done) begin errors++; $display("FAIL job_timeout src=%0d cnt=%0d: no done within %0d cycles", src, cnt, w); end
    for (int k = 0; k < 3; k++) begin
      exp_done = (n == 0) ? t0 : t0 + n + lat_of[k] + 3;
      checks++; if (dn_tot[k] - s_dn[k] !== 1) begin errors++; $display("FAIL done_count lat%0d: got %0d expected 1", lat_of[k], dn_tot[k] - s_dn[k]); end
      checks++; if (dn_cyc[k] !== exp_done) begin errors++; $display("FAIL done_latency lat%0d n=%0d: got %0d expected %0d", lat_of[k], n, dn_cyc[k] - t0 + 1, exp_done - t0 + 1); end
      checks++; if (busy_tot[k] - s_busy[k] !== exp_done - t0 + 1) begin errors++; $display("FAIL busy_cycles lat%0d: got %0d expected %0d", lat_of[k], busy_tot[k] - s_busy[k], exp_done - t0 + 1); end
      checks++; if (rd_tot[k] - s_rd[k] !== n) begin errors++; $display("FAIL read_count lat%0d: got %0d expected %0d", lat_of[k], rd_tot[k] - s_rd[k], n); end
      checks++; if (ld_tot[k] - s_ld[k] !== n) begin errors++; $display("FAIL load_count lat%0d: got %0d expected %0d", lat_of[k], ld_tot[k] - s_ld[k], n); end
      checks++; if (excl_tot[k] - s_ex[k] !== 0) begin errors++; $display("FAIL strobe_exclusive lat%0d: got %0d overlaps expected 0", lat_of[k], excl_tot[k] - s_ex[k]); end
      bad = 0;
      for (int i = 0; i < n && i < rd_tot[k] - s_rd[k] && i < ld_tot[k] - s_ld[k]; i++) begin
        if (rd_addr[k][(s_rd[k] + i) % 256] !== 5'((src + i) % 32)) bad++;
        if (rd_cyc[k][(s_rd[k] + i) % 256] !== t0 + 1 + i) bad++;
        if (ld_cyc[k][(s_ld[k] + i) % 256] !== t0 + 1 + i + lat_of[k]) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL read_load_timing lat%0d: got %0d wrong addr/cycle entries expected 0", lat_of[k], bad); end
      if (n > 0) begin
        checks++; if (clr_tot[k] - s_clr[k] !== 1) begin errors++; $display("FAIL clear_count lat%0d: got %0d expected 1", lat_of[k], clr_tot[k] - s_clr[k]); end
        checks++; if (xf_tot[k] - s_xf[k] !== 1 || xf_cyc[k] !== exp_done - 2) begin errors++; $display("FAIL transfer lat%0d: got count %0d cyc %0d expected 1 at %0d", lat_of[k], xf_tot[k] - s_xf[k], xf_cyc[k], exp_done - 2); end
        checks++; if (wr_tot[k] - s_wr[k] !== 1 || wr_cyc[k] !== exp_done - 1) begin errors++; $display("FAIL write lat%0d: got count %0d cyc %0d expected 1 at %0d", lat_of[k], wr_tot[k] - s_wr[k], wr_cyc[k], exp_done - 1); end
        checks++; if (wr_addr[k] !== 5'(dst)) begin errors++; $display("FAIL write_addr lat%0d: got %0d expected %0d", lat_of[k], wr_addr[k], dst); end
        checks++; if (wr_data[k] !== sum) begin errors++; $display("FAIL write_sum lat%0d: got %0d expected %0d", lat_of[k], wr_data[k], sum); end
        checks++; if (dn_addr[k] !== 5'(dst)) begin errors++; $display("FAIL addr_hold lat%0d: got %0d expected %0d", lat_of[k], dn_addr[k], dst); end
      end else begin
        checks++; if ((clr_tot[k] - s_clr[k]) + (xf_tot[k] - s_xf[k]) + (wr_tot[k] - s_wr[k]) !== 0) begin errors++; $display("FAIL empty_strobes lat%0d: got %0d strobes expected 0", lat_of[k], (clr_tot[k] - s_clr[k]) + (xf_tot[k] - s_xf[k]) + (wr_tot[k] - s_wr[k])); end
      end
    end
    if (n > 0) exp_mem[dst % 32] = sum;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (m_busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy lat%0d: got %b expected 0", lat_of[k], m_busy[k]); end
      checks++; if (m_dn[k] !== 1'b0) begin errors++; $display("FAIL reset_done lat%0d: got %b expected 0", lat_of[k], m_dn[k]); end
      checks++; if ({m_rd[k], m_wr[k], m_clr[k], m_ld[k], m_xf[k]} !== 5'b0) begin errors++; $display("FAIL reset_strobes lat%0d: got %b expected 00000", lat_of[k], {m_rd[k], m_wr[k], m_clr[k], m_ld[k], m_xf[k]}); end
      checks++; if (m_addr[k] !== 5'd0) begin errors++; $display("FAIL reset_addr lat%0d: got %0d expected 0", lat_of[k], m_addr[k]); end
`ifdef ACC_SEQ_RANGE_CHECK_EN
      checks++; if (m_err[k] !== 1'b0) begin errors++; $display("FAIL reset_error lat%0d: got %b expected 0", lat_of[k], m_err[k]); end
`endif
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_job(4, 4, 20, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (dmem[k][20] !== 16'd10) begin errors++; $display("FAIL basic_mem20 lat%0d: got %0d expected 10", lat_of[k], dmem[k][20]); end
    end
  endtask

  task automatic test_wrap();
`ifdef ACC_SEQ_RANGE_CHECK_EN
    int t0;
    int s_rd[3], s_busy[3], s_dn[3], s_err[3];
    for (int k = 0; k < 3; k++) begin
      s_rd[k] = rd_tot[k]; s_busy[k] = busy_tot[k]; s_dn[k] = dn_tot[k]; s_err[k] = err_tot[k];
    end
    @(negedge clock);
    src_base = 5'd30; count = 6'd4; dst_addr = 5'd2; start = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    start = 1'b0;
    repeat (6) @(negedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (err_tot[k] - s_err[k] !== 1 || err_cyc[k] !== t0) begin errors++; $display("FAIL reject_error lat%0d: got %0d pulses at %0d expected 1 at %0d", lat_of[k], err_tot[k] - s_err[k], err_cyc[k], t0); end
      checks++; if ((rd_tot[k] - s_rd[k]) + (busy_tot[k] - s_busy[k]) + (dn_tot[k] - s_dn[k]) !== 0) begin errors++; $display("FAIL reject_activity lat%0d: got %0d expected 0", lat_of[k], (rd_tot[k] - s_rd[k]) + (busy_tot[k] - s_busy[k]) + (dn_tot[k] - s_dn[k])); end
    end
`else
    run_job(30, 4, 2, 1'b0);
`endif
  endtask

  task automatic test_empty_and_saturate();
    run_job(9, 0, 3, 1'b0);
`ifdef ACC_SEQ_RANGE_CHECK_EN
    run_job(0, 40, 3, 1'b0);
`else
    run_job(7, 40, 3, 1'b0);
`endif
  endtask

  task automatic test_latency();
    run_job(16, 2, 30, 1'b0);
  endtask

  task automatic test_ignored_start();
    run_job(12, 5, 2, 1'b1);
  endtask

  task automatic test_back_to_back();
    int t0, w, bad;
    int s_rd, s_dn, s_busy;
    logic [15:0] sum;
    s_rd = rd_tot[1]; s_dn = dn_tot[1]; s_busy = busy_tot[1];
    sum = exp_mem[10] + exp_mem[11];
    @(negedge clock);
    src_base = 5'd10; count = 6'd2; dst_addr = 5'd25; start = 1'b1;
    @(posedge clock); #1;
    t0 = cyc;
    w = 0;
    while (dn_tot[1] - s_dn < 2 && w < 60) begin @(negedge clock); #1; w++; end
    start = 1'b0;
    checks++; if (dn_tot[1] - s_dn !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", dn_tot[1] - s_dn); end
    checks++; if (dn_cyc[1] !== t0 + 14) begin errors++; $display("FAIL b2b_second_done: got %0d expected %0d", dn_cyc[1] - t0, 14); end
    checks++; if (busy_tot[1] - s_busy !== 14) begin errors++; $display("FAIL b2b_busy: got %0d expected 14", busy_tot[1] - s_busy); end
    bad = 0;
    for (int i = 0; i < 4 && i < rd_tot[1] - s_rd; i++)
      if (rd_addr[1][(s_rd + i) % 256] !== 5'(10 + (i % 2))) bad++;
    checks++; if (rd_tot[1] - s_rd !== 4 || bad !== 0) begin errors++; $display("FAIL b2b_reads: got %0d reads %0d bad expected 4 reads 0 bad", rd_tot[1] - s_rd, bad); end
    exp_mem[25] = sum;
    w = 0;
    while (m_busy !== 3'b000 && w < 40) begin @(negedge clock); #1; w++; end
    checks++; if (m_busy !== 3'b000) begin errors++; $display("FAIL b2b_idle_timeout: got busy %b expected 000", m_busy); end
  endtask

  task automatic test_reset_mid_job();
    int s_wr[3], s_dn[3];
    for (int k = 0; k < 3; k++) begin s_wr[k] = wr_tot[k]; s_dn[k] = dn_tot[k]; end
    @(negedge clock);
    src_base = 5'd3; count = 6'd4; dst_addr = 5'd15; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ({m_busy[k], m_dn[k], m_rd[k], m_wr[k], m_clr[k], m_ld[k], m_xf[k]} !== 7'b0 || m_addr[k] !== 5'd0) begin
        errors++; $display("FAIL midreset_outputs lat%0d: got %b addr %0d expected all 0", lat_of[k], {m_busy[k], m_dn[k], m_rd[k], m_wr[k], m_clr[k], m_ld[k], m_xf[k]}, m_addr[k]);
      end
    end
    reset = 1'b0;
    repeat (15) @(negedge clock);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if ((wr_tot[k] - s_wr[k]) + (dn_tot[k] - s_dn[k]) !== 0) begin errors++; $display("FAIL midreset_abort lat%0d: got %0d write/done expected 0", lat_of[k], (wr_tot[k] - s_wr[k]) + (dn_tot[k] - s_dn[k])); end
    end
    run_job(3, 4, 15, 1'b0);
  endtask

  task automatic test_random();
    int src, cnt, n;
    for (int j = 0; j < 8; j++) begin
      src = int'($urandom_range(0, 31));
      cnt = int'($urandom_range(0, 40));
`ifdef ACC_SEQ_RANGE_CHECK_EN
      n = (cnt > 32) ? 32 : cnt;
      if (src + n > 32) src = 32 - n;
`else
      n = cnt;
`endif
      run_job(src, cnt, int'($urandom_range(0, 31)), n[0]);
    end
  endtask

  initial begin
    for (int a = 0; a < 32; a++) exp_mem[a] = 16'($urandom_range(0, 999));
    exp_mem[4] = 16'd1; exp_mem[5] = 16'd2; exp_mem[6] = 16'd3; exp_mem[7] = 16'd4;
    test_reset();
    test_basic();
    test_wrap();
    test_empty_and_saturate();
    test_latency();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_job();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
